// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch-stage program counter with next-PC select and return-address stack
module pc_sequencer #(
  parameter int WIDTH     = 16,
  parameter int INC       = 2,
  parameter int RAS_DEPTH = 4,
  parameter int RESET_VEC = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             conPCWrite,
  input  logic             conBranch,
  input  logic [WIDTH-1:0] inPCAddSE,
  input  logic             conJump,
  input  logic [WIDTH-1:0] inJumpTarget,
  input  logic             conCall,
  input  logic             conReturn,
  output logic [WIDTH-1:0] outPC,
  output logic [WIDTH-1:0] outPCPlus,
  output logic             outRASEmpty,
  output logic             outRASFull,
  output logic             outRASOverflow,
  output logic             outRASUnderflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam logic [WIDTH-1:0] RST_PC   = WIDTH'(RESET_VEC);
  localparam logic [WIDTH-1:0] INC_W    = WIDTH'(INC);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(RAS_DEPTH);

  logic [WIDTH-1:0] pcReg;
  logic [WIDTH-1:0] nextPC;
  logic [WIDTH-1:0] rasMem [RAS_DEPTH];
  logic [PTR_W-1:0] topPtr;
  logic [PTR_W-1:0] writePtr;
  logic [PTR_W:0]   rasCount;
  logic             ovfFlag;
  logic             unfFlag;
  logic             doPush;
  logic             doReplace;
  logic             doPop;

  assign outPC           = pcReg;
  assign outPCPlus       = pcReg + INC_W;
  assign outRASEmpty     = (rasCount == '0);
  assign outRASFull      = (rasCount == FULL_CNT);
  assign outRASOverflow  = ovfFlag;
  assign outRASUnderflow = unfFlag;

  // A call paired with a return on a non-empty stack overwrites the top in place;
  // on an empty stack it degenerates to an ordinary push.
  always_comb begin
    doReplace = conCall && conReturn && !outRASEmpty;
    doPush    = conCall && !doReplace;
    doPop     = conReturn && !conCall && !outRASEmpty;
    writePtr  = doReplace ? topPtr : topPtr + 1'b1;

    nextPC = outPCPlus;
    if (conReturn) begin
      nextPC = outRASEmpty ? outPCPlus : rasMem[topPtr];
    end else if (conCall || conJump) begin
      nextPC = inJumpTarget;
    end else if (conBranch) begin
      nextPC = outPCPlus + inPCAddSE;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pcReg    <= RST_PC;
      topPtr   <= '0;
      rasCount <= '0;
      ovfFlag  <= 1'b0;
      unfFlag  <= 1'b0;
    end else if (conPCWrite) begin
      pcReg <= nextPC;
      if (doPush) begin
        topPtr <= topPtr + 1'b1;
        if (outRASFull) begin
          ovfFlag <= 1'b1;
        end else begin
          rasCount <= rasCount + 1'b1;
        end
      end else if (doPop) begin
        topPtr   <= topPtr - 1'b1;
        rasCount <= rasCount - 1'b1;
      end
      if (conReturn && outRASEmpty) begin
        unfFlag <= 1'b1;
      end
    end
  end

  // Entry contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge CLK) begin
    if (conPCWrite && (doPush || doReplace)) begin
      rasMem[writePtr] <= outPCPlus;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer against a queue-based model
module tb_pc_sequencer;
  localparam int WIDTH = 16;
  localparam int INC   = 2;
  localparam int DEPTH = 4;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             conPCWrite = 1'b0;
  logic             conBranch = 1'b0;
  logic [WIDTH-1:0] inPCAddSE = '0;
  logic             conJump = 1'b0;
  logic [WIDTH-1:0] inJumpTarget = '0;
  logic             conCall = 1'b0;
  logic             conReturn = 1'b0;
  logic [WIDTH-1:0] outPC;
  logic [WIDTH-1:0] outPCPlus;
  logic             outRASEmpty;
  logic             outRASFull;
  logic             outRASOverflow;
  logic             outRASUnderflow;

  int nChecks = 0;
  int nErrors = 0;

  logic [WIDTH-1:0] mPC;
  logic [WIDTH-1:0] mRas[$];
  bit               mOvf;
  bit               mUnf;

  pc_sequencer #(.WIDTH(WIDTH), .INC(INC), .RAS_DEPTH(DEPTH), .RESET_VEC(0)) dut (
    .CLK(CLK), .RST(RST), .conPCWrite(conPCWrite), .conBranch(conBranch),
    .inPCAddSE(inPCAddSE), .conJump(conJump), .inJumpTarget(inJumpTarget),
    .conCall(conCall), .conReturn(conReturn), .outPC(outPC), .outPCPlus(outPCPlus),
    .outRASEmpty(outRASEmpty), .outRASFull(outRASFull),
    .outRASOverflow(outRASOverflow), .outRASUnderflow(outRASUnderflow)
  );

  always #5 CLK = ~CLK;

  task automatic resetDut();
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    mPC = '0;
    mRas.delete();
    mOvf = 0;
    mUnf = 0;
  endtask

  // Drives one clock of stimulus and advances the reference model by the stated rules.
  task automatic cyc(input bit wr, input bit br, input bit jmp, input bit call, input bit ret,
                     input logic [WIDTH-1:0] off, input logic [WIDTH-1:0] tgt);
    logic [WIDTH-1:0] pcp;
    logic [WIDTH-1:0] npc;
    conPCWrite = wr; conBranch = br; conJump = jmp; conCall = call; conReturn = ret;
    inPCAddSE = off; inJumpTarget = tgt;
    pcp = mPC + WIDTH'(INC);
    npc = mPC;
    if (wr) begin
      if (ret) npc = (mRas.size() == 0) ? pcp : mRas[mRas.size()-1];
      else if (call || jmp) npc = tgt;
      else if (br) npc = pcp + off;
      else npc = pcp;
      if (ret && mRas.size() == 0) mUnf = 1;
      if (call) begin
        if (ret && mRas.size() > 0) begin
          mRas[mRas.size()-1] = pcp;
        end else begin
          if (mRas.size() == DEPTH) begin
            void'(mRas.pop_front());
            mOvf = 1;
          end
          mRas.push_back(pcp);
        end
      end else if (ret && mRas.size() > 0) begin
        void'(mRas.pop_back());
      end
    end
    @(posedge CLK);
    #1;
    mPC = npc;
    conPCWrite = 0; conBranch = 0; conJump = 0; conCall = 0; conReturn = 0;
  endtask

  task automatic test_reset();
    resetDut();
    nChecks++;
    if (outPC !== 16'h0000 || outRASEmpty !== 1'b1 || outRASFull !== 1'b0 ||
        outRASOverflow !== 1'b0 || outRASUnderflow !== 1'b0) begin
      nErrors++;
      $display("FAIL reset: pc=%h e=%b f=%b o=%b u=%b", outPC, outRASEmpty, outRASFull,
               outRASOverflow, outRASUnderflow);
    end
    for (int i = 1; i <= 3; i++) begin
      cyc(1, 0, 0, 0, 0, '0, '0);
      nChecks++;
      if (outPC !== 16'(2 * i) || outPCPlus !== 16'(2 * i + 2) || outRASEmpty !== 1'b1) begin
        nErrors++;
        $display("FAIL sequential[%0d]: pc=%h plus=%h empty=%b exp pc=%h", i, outPC, outPCPlus,
                 outRASEmpty, 16'(2 * i));
      end
    end
  endtask

  task automatic test_branch_stall();
    resetDut();
    cyc(1, 0, 1, 0, 0, '0, 16'h0010);
    cyc(1, 1, 0, 0, 0, 16'hFFF8, '0);
    nChecks++;
    if (outPC !== 16'h000A) begin
      nErrors++; $display("FAIL branch: pc=%h exp 000a", outPC);
    end
    cyc(0, 0, 1, 0, 0, '0, 16'h1234);
    cyc(0, 0, 1, 1, 0, '0, 16'h1234);
    nChecks++;
    if (outPC !== 16'h000A || outRASEmpty !== 1'b1) begin
      nErrors++; $display("FAIL stall: pc=%h empty=%b exp 000a/1", outPC, outRASEmpty);
    end
  endtask

  task automatic test_call_return();
    resetDut();
    cyc(1, 0, 1, 0, 0, '0, 16'h0020);
    cyc(1, 0, 0, 1, 0, '0, 16'h0100);
    nChecks++;
    if (outPC !== 16'h0100 || outRASEmpty !== 1'b0) begin
      nErrors++; $display("FAIL call: pc=%h empty=%b exp 0100/0", outPC, outRASEmpty);
    end
    cyc(1, 0, 0, 0, 0, '0, '0);
    cyc(1, 0, 0, 0, 0, '0, '0);
    cyc(1, 0, 0, 0, 1, '0, '0);
    nChecks++;
    if (outPC !== 16'h0022 || outRASEmpty !== 1'b1) begin
      nErrors++; $display("FAIL return: pc=%h empty=%b exp 0022/1", outPC, outRASEmpty);
    end
  endtask

  task automatic test_overflow();
    logic [WIDTH-1:0] expRet [4] = '{16'h0052, 16'h0042, 16'h0032, 16'h0022};
    resetDut();
    for (int i = 1; i <= 5; i++) begin
      cyc(1, 0, 1, 0, 0, '0, 16'(16 * i));
      cyc(1, 0, 0, 1, 0, '0, 16'h0200);
    end
    nChecks++;
    if (outRASFull !== 1'b1 || outRASOverflow !== 1'b1 || outRASUnderflow !== 1'b0) begin
      nErrors++; $display("FAIL overflow flags: full=%b ovf=%b unf=%b exp 1/1/0", outRASFull,
                          outRASOverflow, outRASUnderflow);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0, 0, 1, '0, '0);
      nChecks++;
      if (outPC !== expRet[i]) begin
        nErrors++; $display("FAIL overflow return[%0d]: pc=%h exp %h", i, outPC, expRet[i]);
      end
    end
    cyc(1, 0, 0, 0, 1, '0, '0);
    nChecks++;
    if (outPC !== 16'h0024 || outRASUnderflow !== 1'b1 || outRASEmpty !== 1'b1) begin
      nErrors++; $display("FAIL underflow: pc=%h unf=%b empty=%b exp 0024/1/1", outPC,
                          outRASUnderflow, outRASEmpty);
    end
  endtask

  task automatic test_priority();
    resetDut();
    cyc(1, 0, 1, 0, 0, '0, 16'h02FE);
    cyc(1, 0, 0, 1, 0, '0, 16'h0500);
    cyc(1, 1, 1, 0, 1, 16'h0100, 16'h0700);
    nChecks++;
    if (outPC !== 16'h0300 || outRASEmpty !== 1'b1) begin
      nErrors++; $display("FAIL ret+jump+branch: pc=%h empty=%b exp 0300/1", outPC, outRASEmpty);
    end
    cyc(1, 0, 1, 0, 0, '0, 16'h02FE);
    cyc(1, 0, 0, 1, 0, '0, 16'h0040);
    cyc(1, 0, 0, 1, 1, '0, 16'h0900);
    nChecks++;
    if (outPC !== 16'h0300 || outRASEmpty !== 1'b0 || outRASFull !== 1'b0) begin
      nErrors++; $display("FAIL call+ret: pc=%h empty=%b full=%b exp 0300/0/0", outPC,
                          outRASEmpty, outRASFull);
    end
    cyc(1, 0, 0, 0, 1, '0, '0);
    nChecks++;
    if (outPC !== 16'h0042 || outRASEmpty !== 1'b1 || outRASUnderflow !== 1'b0) begin
      nErrors++; $display("FAIL replaced top: pc=%h empty=%b unf=%b exp 0042/1/0", outPC,
                          outRASEmpty, outRASUnderflow);
    end
    cyc(1, 0, 0, 1, 1, '0, 16'h0900);
    nChecks++;
    if (outPC !== 16'h0044 || outRASEmpty !== 1'b0 || outRASUnderflow !== 1'b1) begin
      nErrors++; $display("FAIL call+ret empty: pc=%h empty=%b unf=%b exp 0044/0/1", outPC,
                          outRASEmpty, outRASUnderflow);
    end
  endtask

  task automatic test_wrap_async_reset();
    resetDut();
    cyc(1, 0, 1, 0, 0, '0, 16'hFFFE);
    cyc(1, 0, 0, 0, 0, '0, '0);
    nChecks++;
    if (outPC !== 16'h0000) begin
      nErrors++; $display("FAIL wrap: pc=%h exp 0000", outPC);
    end
    cyc(1, 0, 1, 0, 0, '0, 16'h0010);
    cyc(1, 0, 0, 0, 1, '0, '0);
    cyc(1, 0, 0, 1, 0, '0, 16'h0300);
    #2;
    RST = 1'b1;
    #1;
    nChecks++;
    if (outPC !== 16'h0000 || outRASUnderflow !== 1'b0 || outRASEmpty !== 1'b1) begin
      nErrors++; $display("FAIL async reset: pc=%h unf=%b empty=%b exp 0000/0/1", outPC,
                          outRASUnderflow, outRASEmpty);
    end
    @(posedge CLK);
    #1;
    RST = 1'b0;
    mPC = '0; mRas.delete(); mOvf = 0; mUnf = 0;
  endtask

  task automatic test_random();
    int bad;
    resetDut();
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
          16'($urandom), 16'($urandom));
      nChecks++;
      bad = (outPC !== mPC) || (outPCPlus !== mPC + 16'(INC)) ||
            (outRASEmpty !== (mRas.size() == 0)) || (outRASFull !== (mRas.size() == DEPTH)) ||
            (outRASOverflow !== mOvf) || (outRASUnderflow !== mUnf);
      if (bad) begin
        nErrors++;
        $display("FAIL random[%0d]: pc=%h e=%b f=%b o=%b u=%b exp pc=%h depth=%0d o=%b u=%b", i,
                 outPC, outRASEmpty, outRASFull, outRASOverflow, outRASUnderflow, mPC,
                 mRas.size(), mOvf, mUnf);
      end
      if ($urandom_range(0, 99) == 0) resetDut();
    end
  endtask

  initial begin
    test_reset();
    test_branch_stall();
    test_call_return();
    test_overflow();
    test_priority();
    test_wrap_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end
endmodule
